// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap1_pkg
// Description : Shared definitions for the SAP-1 datapath and sequencer.
//               Covers control-word bit positions, opcodes and one-hot
//               T-state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package sap1_pkg;

    // Control-word bit positions. The word is MSB first:
    // CP EP LM CE LI EI LA EA SU EU LB LO
    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // Opcodes carried in IR[7:4]
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // One-hot sequencer T-states
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

endpackage : sap1_pkg
`default_nettype wire

// File: rtl/sap1_ram16x8.sv
`default_nettype none
// ============================================================================
// Module      : sap1_ram16x8
// Description : Program/data RAM for SAP-1. Asynchronous read, synchronous
//               write. The read port sees the pre-edge contents, so a write
//               and a read to the same address in one cycle return the old
//               word, and the new word appears on the following cycle.
// Ports       : clk            - clock
//               we/waddr/wdata - synchronous write port
//               raddr/rdata    - asynchronous read port
// Revision    : 1.0  initial release
// ============================================================================
module sap1_ram16x8 #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately left out of reset so that a clr does not
    // erase a loaded program.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : sap1_ram16x8
`default_nettype wire

// File: rtl/sap1_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sap1_datapath
// Description : SAP-1 register-and-bus datapath. Each cycle one source is
//               gated onto the W bus. The destinations named in the control
//               word load from it on the rising edge. The IR opcode nibble is
//               returned to the sequencer.
// Ports       : clk          - clock
//               clr          - synchronous active-high reset
//               con_signals  - control word CP EP LM CE LI EI LA EA SU EU LB LO
//               prog_*       - RAM program-load write port
//               op_code      - IR[7:4]
//               out_port     - output register
//               w_bus        - current bus value
//               pc           - program counter
//               bus_conflict - sticky multiple-driver flag
// Revision    : 1.0  initial release
// ============================================================================
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CW_W-1:0]   con_signals,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        op_code,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] w_bus,
    output logic [3:0]        pc,
    output logic              bus_conflict
);

    localparam logic [DATA_W-1:0] c_one  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_zero = '0;

    // ------------------------------------------------------------------
    // Architectural registers
    // ------------------------------------------------------------------
    logic [3:0]        r_pc;
    logic [3:0]        r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_conflict;

    logic [3:0]        w_pc_nxt;
    logic [3:0]        w_mar_nxt;
    logic [DATA_W-1:0] w_ir_nxt;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [DATA_W-1:0] w_out_nxt;
    logic              w_conflict_nxt;

    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_bus_val;
    logic [4:0]        w_en;
    logic              w_multi_en;

    // ------------------------------------------------------------------
    // RAM: read at MAR, written only from the program-load port
    // ------------------------------------------------------------------
    sap1_ram16x8 #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (r_mar),
        .rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // ALU: subtraction is A + ~B + 1. The carry out is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_alu = r_a + r_b;
        if (con_signals[CW_SU]) begin
            w_alu = r_a + ~r_b + c_one;
        end
    end

    // ------------------------------------------------------------------
    // Bus mux with fixed priority EP > CE > EI > EA > EU
    // ------------------------------------------------------------------
    always_comb begin
        w_en = {con_signals[CW_EP], con_signals[CW_CE], con_signals[CW_EI],
                con_signals[CW_EA], con_signals[CW_EU]};
        // Clearing the lowest set bit leaves something only if two or more
        // enables are active.
        w_multi_en = (w_en & (w_en - 5'd1)) != 5'd0;

        w_bus_val = c_zero;
        if (con_signals[CW_EP]) begin
            w_bus_val = {{(DATA_W-4){1'b0}}, r_pc};
        end else if (con_signals[CW_CE]) begin
            w_bus_val = w_ram_rdata;
        end else if (con_signals[CW_EI]) begin
            w_bus_val = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
        end else if (con_signals[CW_EA]) begin
            w_bus_val = r_a;
        end else if (con_signals[CW_EU]) begin
            w_bus_val = w_alu;
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the registers. Loads sample the bus of this cycle.
    // LA+EU therefore captures an ALU result built from the pre-edge A.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_nxt       = r_pc;
        w_mar_nxt      = r_mar;
        w_ir_nxt       = r_ir;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_out_nxt      = r_out;
        w_conflict_nxt = r_conflict | w_multi_en;

        if (con_signals[CW_CP]) w_pc_nxt  = r_pc + 4'd1;
        if (con_signals[CW_LM]) w_mar_nxt = w_bus_val[3:0];
        if (con_signals[CW_LI]) w_ir_nxt  = w_bus_val;
        if (con_signals[CW_LA]) w_a_nxt   = w_bus_val;
        if (con_signals[CW_LB]) w_b_nxt   = w_bus_val;
        if (con_signals[CW_LO]) w_out_nxt = w_bus_val;
    end

    // clr overrides any load or increment requested in the same cycle
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc       <= 4'h0;
            r_mar      <= 4'h0;
            r_ir       <= c_zero;
            r_a        <= c_zero;
            r_b        <= c_zero;
            r_out      <= c_zero;
            r_conflict <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_mar      <= w_mar_nxt;
            r_ir       <= w_ir_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_out      <= w_out_nxt;
            r_conflict <= w_conflict_nxt;
        end
    end

    assign op_code      = r_ir[DATA_W-1 -: 4];
    assign out_port     = r_out;
    assign w_bus        = w_bus_val;
    assign pc           = r_pc;
    assign bus_conflict = r_conflict;

endmodule : sap1_datapath
`default_nettype wire

// File: tb/tb_sap1_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap1_datapath
// Description : Directed self-checking bench for sap1_datapath.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sap1_datapath;

    // Control-word bits, written out independently of the design package
    localparam logic [11:0] c_cp = 12'h800;
    localparam logic [11:0] c_ep = 12'h400;
    localparam logic [11:0] c_lm = 12'h200;
    localparam logic [11:0] c_ce = 12'h100;
    localparam logic [11:0] c_li = 12'h080;
    localparam logic [11:0] c_ei = 12'h040;
    localparam logic [11:0] c_la = 12'h020;
    localparam logic [11:0] c_ea = 12'h010;
    localparam logic [11:0] c_su = 12'h008;
    localparam logic [11:0] c_eu = 12'h004;
    localparam logic [11:0] c_lb = 12'h002;
    localparam logic [11:0] c_lo = 12'h001;

    logic        clk;
    logic        clr;
    logic [11:0] con_signals;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  op_code;
    logic [7:0]  out_port;
    logic [7:0]  w_bus;
    logic [3:0]  pc;
    logic        bus_conflict;

    int n_cmp;
    int n_bad;

    sap1_datapath #(
        .RAM_DEPTH (16),
        .DATA_W    (8)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .con_signals  (con_signals),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .op_code      (op_code),
        .out_port     (out_port),
        .w_bus        (w_bus),
        .pc           (pc),
        .bus_conflict (bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [11:0] cw);
        con_signals = cw;
        tick();
        con_signals = 12'h000;
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic fetch();
        step(c_ep | c_lm);
        step(c_cp);
        step(c_ce | c_li);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        prog(4'h0, 8'hE5);
        step(c_ce | c_li | c_la | c_lb | c_lo);
        step(c_cp);
        step(c_cp);
        step(c_cp);
        n_cmp++;
        if (pc !== 4'h3 || out_port !== 8'hE5 || op_code !== 4'hE) begin
            n_bad++;
            $display("FAIL reset_preload pc=%h out=%h op=%h want 3/e5/e", pc, out_port, op_code);
        end
        // Two clr cycles while loads and CP are requested
        clr = 1'b1;
        step(c_cp | c_ce | c_la | c_lo);
        step(c_cp | c_ce | c_la | c_lo);
        clr = 1'b0;
        n_cmp++;
        if (pc !== 4'h0 || out_port !== 8'h00 || op_code !== 4'h0 || bus_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regs pc=%h out=%h op=%h conf=%b want 0/00/0/0",
                     pc, out_port, op_code, bus_conflict);
        end
        con_signals = 12'h000;
        #1;
        n_cmp++;
        if (w_bus !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_idle_bus got %h want 00", w_bus);
        end
        con_signals = c_ea;
        #1;
        n_cmp++;
        if (w_bus !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_a got %h want 00", w_bus);
        end
        con_signals = c_ce;
        #1;
        n_cmp++;
        if (w_bus !== 8'hE5) begin
            n_bad++;
            $display("FAIL reset_ram_kept got %h want e5", w_bus);
        end
        con_signals = 12'h000;
    endtask

    task automatic test_fetch();
        do_clr();
        prog(4'h0, 8'h09);
        con_signals = c_ep | c_lm;
        #1;
        n_cmp++;
        if (w_bus !== 8'h00) begin
            n_bad++;
            $display("FAIL fetch_t1_bus got %h want 00", w_bus);
        end
        tick();
        step(c_cp);
        con_signals = c_ce | c_li;
        #1;
        n_cmp++;
        if (w_bus !== 8'h09) begin
            n_bad++;
            $display("FAIL fetch_t3_bus got %h want 09", w_bus);
        end
        tick();
        con_signals = 12'h000;
        n_cmp++;
        if (pc !== 4'h1 || op_code !== 4'h0) begin
            n_bad++;
            $display("FAIL fetch_regs pc=%h op=%h want 1/0", pc, op_code);
        end
        con_signals = c_ei;
        #1;
        n_cmp++;
        if (w_bus !== 8'h09) begin
            n_bad++;
            $display("FAIL fetch_ir_low got %h want 09", w_bus);
        end
        con_signals = 12'h000;
    endtask

    task automatic test_lda_add();
        do_clr();
        prog(4'h0, 8'h09);
        prog(4'h1, 8'h1A);
        prog(4'h9, 8'hF0);
        prog(4'hA, 8'h20);
        fetch();
        step(c_ei | c_lm);
        con_signals = c_ce | c_la;
        #1;
        n_cmp++;
        if (w_bus !== 8'hF0) begin
            n_bad++;
            $display("FAIL lda_t5_bus got %h want f0", w_bus);
        end
        tick();
        fetch();
        n_cmp++;
        if (op_code !== 4'h1 || pc !== 4'h2) begin
            n_bad++;
            $display("FAIL add_fetch op=%h pc=%h want 1/2", op_code, pc);
        end
        step(c_ei | c_lm);
        step(c_ce | c_lb);
        con_signals = c_eu | c_la;
        #1;
        n_cmp++;
        if (w_bus !== 8'h10) begin
            n_bad++;
            $display("FAIL add_alu got %h want 10", w_bus);
        end
        tick();
        con_signals = c_ea;
        #1;
        n_cmp++;
        if (w_bus !== 8'h10) begin
            n_bad++;
            $display("FAIL add_result_a got %h want 10", w_bus);
        end
        con_signals = 12'h000;
    endtask

    task automatic test_sub_out();
        do_clr();
        prog(4'h0, 8'h05);
        step(c_ce | c_la);
        prog(4'h0, 8'h07);
        step(c_ce | c_lb);
        con_signals = c_eu | c_la | c_su;
        #1;
        n_cmp++;
        if (w_bus !== 8'hFE) begin
            n_bad++;
            $display("FAIL sub_alu got %h want fe", w_bus);
        end
        tick();
        con_signals = c_eu;
        #1;
        n_cmp++;
        if (w_bus !== 8'h05) begin
            n_bad++;
            $display("FAIL add_after_sub got %h want 05", w_bus);
        end
        step(c_ea | c_lo);
        n_cmp++;
        if (out_port !== 8'hFE) begin
            n_bad++;
            $display("FAIL out_reg got %h want fe", out_port);
        end
    endtask

    task automatic test_rw_collision();
        // MAR is 0 and RAM[0] holds 07 from the previous test
        prog_we     = 1'b1;
        prog_addr   = 4'h0;
        prog_data   = 8'h3C;
        con_signals = c_ce | c_la;
        #1;
        n_cmp++;
        if (w_bus !== 8'h07) begin
            n_bad++;
            $display("FAIL rw_old_word got %h want 07", w_bus);
        end
        tick();
        prog_we     = 1'b0;
        con_signals = c_ea;
        #1;
        n_cmp++;
        if (w_bus !== 8'h07) begin
            n_bad++;
            $display("FAIL rw_a_loaded got %h want 07", w_bus);
        end
        con_signals = c_ce;
        #1;
        n_cmp++;
        if (w_bus !== 8'h3C) begin
            n_bad++;
            $display("FAIL rw_new_word got %h want 3c", w_bus);
        end
        con_signals = 12'h000;
    endtask

    task automatic test_conflict_wrap();
        do_clr();
        step(c_cp);
        step(c_cp);
        step(c_cp);
        prog(4'h0, 8'h81);
        step(c_ce | c_la);
        con_signals = c_ep | c_ea;
        #1;
        n_cmp++;
        if (w_bus !== 8'h03 || bus_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_bus got %h conf=%b want 03/0", w_bus, bus_conflict);
        end
        tick();
        con_signals = 12'h000;
        n_cmp++;
        if (bus_conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL conflict_set got %b want 1", bus_conflict);
        end
        con_signals = c_ei | c_ea;
        #1;
        n_cmp++;
        if (w_bus !== 8'h00) begin
            n_bad++;
            $display("FAIL priority_ei_ea got %h want 00", w_bus);
        end
        con_signals = 12'h000;
        for (int i = 0; i < 12; i++) step(c_cp);
        n_cmp++;
        if (pc !== 4'hF) begin
            n_bad++;
            $display("FAIL pc_reach_f got %h want f", pc);
        end
        step(c_cp);
        n_cmp++;
        if (pc !== 4'h0 || bus_conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL pc_wrap pc=%h conf=%b want 0/1", pc, bus_conflict);
        end
        do_clr();
        n_cmp++;
        if (bus_conflict !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_clr got %b want 0", bus_conflict);
        end
    endtask

    task automatic test_mid_reset();
        do_clr();
        prog(4'h0, 8'h1A);
        prog(4'hA, 8'h20);
        fetch();
        step(c_ei | c_lm);
        // T5 of ADD under clr, with a program write landing in the same cycle
        clr       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'h0;
        prog_data = 8'h11;
        step(c_ce | c_lb);
        clr     = 1'b0;
        prog_we = 1'b0;
        n_cmp++;
        if (pc !== 4'h0 || op_code !== 4'h0) begin
            n_bad++;
            $display("FAIL midclr_regs pc=%h op=%h want 0/0", pc, op_code);
        end
        step(c_ce | c_la);
        con_signals = c_eu;
        #1;
        // A = 11 from the write during clr; B must be 00, not 20
        n_cmp++;
        if (w_bus !== 8'h11) begin
            n_bad++;
            $display("FAIL midclr_b got A+B=%h want 11", w_bus);
        end
        con_signals = 12'h000;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        clr         = 1'b1;
        con_signals = 12'h000;
        prog_we     = 1'b0;
        prog_addr   = 4'h0;
        prog_data   = 8'h00;
        tick();
        tick();
        clr = 1'b0;

        test_reset();
        test_fetch();
        test_lda_add();
        test_sub_out();
        test_rw_collision();
        test_conflict_wrap();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sap1_datapath
`default_nettype wire

// File: doc/sap1_datapath.md
# sap1_datapath

Register-and-bus datapath of the SAP-1 CPU, and the consuming end of the 12-bit control-word interface that the control sequencer drives. Each cycle it gates one source onto the 8-bit W bus, loads the destination registers named in the control word, and returns the instruction register's opcode nibble to the sequencer. It holds the program counter, MAR, 16x8 RAM, IR, accumulator A, register B, the add/subtract unit and the output register.

## Interface
Parameters:
- RAM_DEPTH, 16, RAM words; fixed by the 4-bit address.
- DATA_W, 8, width of the bus and data registers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset. Synchronous, active-high.
- con_signals  in  12  control word, MSB first: CP EP LM CE LI EI LA EA SU EU LB LO (bit 11 = CP, bit 0 = LO). All bits active-high.
- prog_we  in  1  RAM program-load write strobe.
- prog_addr  in  4  RAM program-load address.
- prog_data  in  8  RAM program-load data.
- op_code  out  4  IR[7:4], returned to the sequencer.
- out_port  out  8  output register.
- w_bus  out  8  current W-bus value, for debug.
- pc  out  4  program counter.
- bus_conflict  out  1  sticky error flag.

## Operation
- **Bus sources**, with the value they drive:
  - EP: {4'h0, PC}
  - CE: RAM[MAR]
  - EI: {4'h0, IR[3:0]}
  - EA: A
  - EU: ALU result
- **Bus idle value:** 8'h00 when no enable is set.
- **Bus conflict:** if more than one enable is set, the bus is still resolved by the priority EP > CE > EI > EA > EU, and bus_conflict is set. The flag is cleared only by clr.
- **Register loads** (rising edge, from the bus value of that cycle):
  - LM: MAR <= bus[3:0]
  - LI: IR <= bus
  - LA: A <= bus
  - LB: B <= bus
  - LO: OUT <= bus
- **PC increment:** CP gives PC <= PC+1, modulo 16, so 4'hF wraps to 4'h0.
- **ALU:** combinational, 8-bit, modulo 256.
  - SU=0: A + B.
  - SU=1: A + ~B + 1, i.e. two's complement A − B.
  - Carry and borrow are discarded.
- **Read-modify-write:** LA together with EU loads A with the ALU result computed from the pre-edge A.
- **RAM:**
  - Asynchronous read at MAR.
  - Synchronous write through the prog_* port only.
  - A write and a CE read of the same address in the same cycle: the read returns the old word, and the new word is visible next cycle.
- **Reset:**
  - clr=1 zeroes PC, MAR, IR, A, B, OUT and bus_conflict on the next edge, even mid-instruction.
  - RAM contents are not cleared.
  - prog_we is still honoured during clr.
- **Register load during clr:** clr has priority over any load or CP in the same cycle.

## Timing
- **Reset value of every output:**
  - op_code = 4'h0 (reads as LDA)
  - out_port = 8'h00
  - pc = 4'h0
  - bus_conflict = 0
  - w_bus = 8'h00 when con_signals = 0
- **Latency:**
  - w_bus and the ALU result are zero-latency combinational from con_signals and the register state.
  - Register outputs change one edge after their load bit is sampled.
- **Fetch, matching the sequencer's T1–T3:**
  - T1 (EP, LM): MAR <= PC.
  - T2 (CP): PC increments.
  - T3 (CE, LI): IR <= RAM[MAR].
  - op_code is valid from the start of T4.
- **Execute:**
  - LDA: T4 EI+LM, then T5 CE+LA.
  - ADD / SUB: T4 EI+LM, T5 CE+LB, T6 EU+LA (with SU=1 for SUB).
  - OUT: T4 EA+LO.
- **No handshake.** The datapath obeys the control word every cycle. Halt is enforced upstream.

## Structure
- **Shared package sap1_pkg:**
  - Control-word bit indices CW_CP=11 … CW_LO=0.
  - Opcodes LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111.
  - One-hot T1–T6 state constants.
- **Sub-module sap1_ram16x8:** RAM with asynchronous read and synchronous write.
- **Top level:** bus mux, conflict detect, ALU and registers.

## Test plan
- **Reset:** hold clr for 2 cycles, with all registers pre-loaded to non-zero values → pc=0, out_port=0, op_code=0, bus_conflict=0. RAM contents are unchanged.
- **Fetch:**
  - Load RAM[0]=8'h09 via prog_*.
  - Apply T1/T2/T3 control words → MAR=0, pc=1, op_code=4'h0.
  - w_bus=8'h09 during T3.
- **LDA / ADD with overflow:**
  - Program: RAM[0]=8'h09, RAM[1]=8'h1A, RAM[9]=8'hF0, RAM[10]=8'h20.
  - Run LDA 9 then ADD 10 → A=8'h10 (wraparound).
- **SUB then OUT:**
  - Start with A=8'h05 and B=8'h07.
  - Apply EU+LA+SU → A=8'hFE.
  - Apply EA+LO → out_port=8'hFE.
- **Conflict and wrap:**
  - Assert EP+EA together → w_bus equals PC, and bus_conflict rises and stays high.
  - With PC=4'hF, apply CP → pc=4'h0.
- **Mid-instruction reset:** assert clr during T5 of ADD with LB set → B=8'h00 next cycle, not the RAM value.
